// File: rtl/tcm_port_arb.sv
// Two-requester arbiter in front of one read-first TCM RAM port: A (CPU) has default
// priority, B (DMA/debug) gets anti-starvation, a bounded burst lock and 1-cycle responses.
module tcm_port_arb #(
    parameter int TCM_MEM_SIZE = 65536,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 16,
    localparam int AW          = $clog2(TCM_MEM_SIZE / 8)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_req_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [63:0]   a_data_i,
    input  logic [7:0]    a_wr_i,
    output logic          a_accept_o,
    output logic          a_resp_valid_o,
    output logic [63:0]   a_resp_data_o,
    input  logic          b_req_i,
    input  logic          b_lock_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [63:0]   b_data_i,
    input  logic [7:0]    b_wr_i,
    output logic          b_accept_o,
    output logic          b_resp_valid_o,
    output logic [63:0]   b_resp_data_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [63:0]   ram_data_o,
    output logic [7:0]    ram_wr_o,
    input  logic [63:0]   ram_data_i,
    output logic          lock_active_o
);

    typedef enum logic [0:0] {
        PRIO_A = 1'b0,
        LOCK_B = 1'b1
    } arb_state_e;

    localparam logic [3:0] STARVE_TOP = 4'(STARVE_LIMIT);
    localparam logic [7:0] LOCK_TOP   = 8'(LOCK_MAX);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic [3:0]    starve_r;
    logic [3:0]    starve_nxt_s;
    logic [7:0]    lock_cnt_r;
    logic [7:0]    lock_cnt_nxt_s;
    logic          a_grant_s;
    logic          b_grant_s;
    logic          a_resp_valid_r;
    logic          b_resp_valid_r;

    // Grant decision; no access is issued while reset is held so no response can be lost.
    always_comb begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
        if (rst_i) begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end else begin
            case (state_r)
                PRIO_A: begin
                    b_grant_s = b_req_i && (!a_req_i || (starve_r == STARVE_TOP));
                    a_grant_s = a_req_i && !b_grant_s;
                end
                LOCK_B: begin
                    // A only gets in on lock timeout or when B has dropped its request
                    a_grant_s = a_req_i && (!b_req_i || (lock_cnt_r == LOCK_TOP));
                    b_grant_s = b_req_i && !a_grant_s;
                end
                default: begin
                    a_grant_s = 1'b0;
                    b_grant_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state for arbitration state, starvation counter and lock hold counter.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        starve_nxt_s   = 4'd0;
        if (b_req_i && !b_grant_s) begin
            if (starve_r >= STARVE_TOP) begin
                starve_nxt_s = STARVE_TOP;
            end else begin
                starve_nxt_s = starve_r + 4'd1;
            end
        end else begin
            starve_nxt_s = 4'd0;
        end
        case (state_r)
            PRIO_A: begin
                if (b_grant_s && b_lock_i) begin
                    state_nxt_s    = LOCK_B;
                    lock_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s    = PRIO_A;
                    lock_cnt_nxt_s = lock_cnt_r;
                end
            end
            LOCK_B: begin
                if (b_grant_s) begin
                    if (lock_cnt_r >= LOCK_TOP) begin
                        lock_cnt_nxt_s = LOCK_TOP;
                    end else begin
                        lock_cnt_nxt_s = lock_cnt_r + 8'd1;
                    end
                end else if (a_grant_s) begin
                    lock_cnt_nxt_s = 8'd0;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
                // Explicit unlock, or B let go of the bus: lock is abandoned
                if (!b_req_i || (b_grant_s && !b_lock_i)) begin
                    state_nxt_s = PRIO_A;
                end else begin
                    state_nxt_s = LOCK_B;
                end
            end
            default: begin
                state_nxt_s    = PRIO_A;
                lock_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // State, counters and response-valid registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= PRIO_A;
            starve_r       <= 4'd0;
            lock_cnt_r     <= 8'd0;
            a_resp_valid_r <= 1'b0;
            b_resp_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            starve_r       <= starve_nxt_s;
            lock_cnt_r     <= lock_cnt_nxt_s;
            a_resp_valid_r <= a_grant_s;
            b_resp_valid_r <= b_grant_s;
        end
    end

    // RAM port mux; idle cycles drive all zeros so no stray write can happen.
    always_comb begin
        ram_addr_o = {AW{1'b0}};
        ram_data_o = 64'd0;
        ram_wr_o   = 8'd0;
        if (a_grant_s) begin
            ram_addr_o = a_addr_i;
            ram_data_o = a_data_i;
            ram_wr_o   = a_wr_i;
        end else if (b_grant_s) begin
            ram_addr_o = b_addr_i;
            ram_data_o = b_data_i;
            ram_wr_o   = b_wr_i;
        end else begin
            ram_addr_o = {AW{1'b0}};
            ram_data_o = 64'd0;
            ram_wr_o   = 8'd0;
        end
    end

    assign a_accept_o     = a_grant_s;
    assign b_accept_o     = b_grant_s;
    assign a_resp_valid_o = a_resp_valid_r;
    assign b_resp_valid_o = b_resp_valid_r;
    assign a_resp_data_o  = a_resp_valid_r ? ram_data_i : 64'd0;
    assign b_resp_data_o  = b_resp_valid_r ? ram_data_i : 64'd0;
    assign lock_active_o  = (state_r == LOCK_B);

endmodule

// File: tb/tb_tcm_port_arb.sv
// Bench for tcm_port_arb: queue-driven requesters, a read-first RAM model, and a rule-level
// arbitration/memory model checked every cycle, plus directed scenarios with literal expectations.
module tb_tcm_port_arb;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;
    localparam int SL    = 4;
    localparam int LM    = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
        logic [7:0]    wr;
        logic          lock;
        int            gap;
    } txn_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          a_req_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0;
    logic [63:0]   a_data_i = 64'd0;
    logic [7:0]    a_wr_i = 8'd0;
    logic          a_accept_o, a_resp_valid_o;
    logic [63:0]   a_resp_data_o;
    logic          b_req_i = 1'b0;
    logic          b_lock_i = 1'b0;
    logic [AW-1:0] b_addr_i = '0;
    logic [63:0]   b_data_i = 64'd0;
    logic [7:0]    b_wr_i = 8'd0;
    logic          b_accept_o, b_resp_valid_o;
    logic [63:0]   b_resp_data_o;
    logic [AW-1:0] ram_addr_o;
    logic [63:0]   ram_data_o;
    logic [7:0]    ram_wr_o;
    logic [63:0]   ram_data_i;
    logic          lock_active_o;

    tcm_port_arb #(.TCM_MEM_SIZE(65536), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_wr_i(a_wr_i),
        .a_accept_o(a_accept_o), .a_resp_valid_o(a_resp_valid_o), .a_resp_data_o(a_resp_data_o),
        .b_req_i(b_req_i), .b_lock_i(b_lock_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
        .b_wr_i(b_wr_i), .b_accept_o(b_accept_o), .b_resp_valid_o(b_resp_valid_o),
        .b_resp_data_o(b_resp_data_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_wr_o(ram_wr_o), .ram_data_i(ram_data_i), .lock_active_o(lock_active_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    function automatic logic [63:0] init_word(input logic [AW-1:0] a);
        return {16'hC0DE, 3'b000, a, 16'h5A5A, 3'b000, a};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] wr);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (wr[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Read-first RAM with one cycle of read latency, plus a preload side door
    logic [63:0]   ram_mem [0:DEPTH-1];
    bit            ram_vld [0:DEPTH-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [63:0]   pl_data = 64'd0;

    function automatic logic [63:0] ram_rd(input logic [AW-1:0] a);
        return ram_vld[a] ? ram_mem[a] : init_word(a);
    endfunction

    always @(posedge clk_i) begin
        ram_data_i <= ram_rd(ram_addr_o);
        if (pl_en) begin
            ram_mem[pl_addr] <= pl_data;
            ram_vld[pl_addr] <= 1'b1;
        end else if (ram_wr_o != 8'd0) begin
            ram_mem[ram_addr_o] <= merge(ram_rd(ram_addr_o), ram_data_o, ram_wr_o);
            ram_vld[ram_addr_o] <= 1'b1;
        end
    end

    // Reference model state: what memory holds and where arbitration stands
    logic [63:0] sh_mem [0:DEPTH-1];
    bit          sh_vld [0:DEPTH-1];
    bit          m_lock = 1'b0;
    int          m_starve = 0;
    int          m_lcnt = 0;
    bit          m_arv = 1'b0, m_brv = 1'b0;
    logic [63:0] m_ard = 64'd0, m_brd = 64'd0;
    bit          last_a_acc = 1'b0, last_b_acc = 1'b0;
    bit          known = 1'b0;
    txn_t        aq[$];
    txn_t        bq[$];
    string       trace = "";
    string       ltrace = "";

    function automatic logic [63:0] sh_rd(input logic [AW-1:0] a);
        return sh_vld[a] ? sh_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%s required=%s", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] w,
                          input int g);
        txn_t t;
        t.addr = a; t.data = d; t.wr = w; t.lock = 1'b0; t.gap = g;
        aq.push_back(t);
    endtask

    task automatic push_b(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] w,
                          input logic l, input int g);
        txn_t t;
        t.addr = a; t.data = d; t.wr = w; t.lock = l; t.gap = g;
        bq.push_back(t);
    endtask

    // One clock cycle: present requests, check outputs against the model, advance the model
    task automatic tick();
        txn_t          t;
        bit            ea, eb, bl;
        logic [AW-1:0] eaddr;
        logic [63:0]   edata;
        logic [7:0]    ewr;
        if (!(a_req_i && !last_a_acc)) begin
            a_req_i = 1'b0; a_addr_i = '0; a_data_i = 64'd0; a_wr_i = 8'd0;
            if (aq.size() > 0) begin
                t = aq[0];
                if (t.gap > 0) begin
                    t.gap--; aq[0] = t;
                end else begin
                    t = aq.pop_front();
                    a_req_i = 1'b1; a_addr_i = t.addr; a_data_i = t.data; a_wr_i = t.wr;
                end
            end
        end
        if (!(b_req_i && !last_b_acc)) begin
            b_req_i = 1'b0; b_lock_i = 1'b0; b_addr_i = '0; b_data_i = 64'd0; b_wr_i = 8'd0;
            if (bq.size() > 0) begin
                t = bq[0];
                if (t.gap > 0) begin
                    t.gap--; bq[0] = t;
                end else begin
                    t = bq.pop_front();
                    b_req_i = 1'b1; b_lock_i = t.lock; b_addr_i = t.addr;
                    b_data_i = t.data; b_wr_i = t.wr;
                end
            end
        end
        #2;
        if (rst_i) begin
            ea = 1'b0; eb = 1'b0;
        end else if (!m_lock) begin
            eb = b_req_i && (!a_req_i || m_starve == SL);
            ea = a_req_i && !eb;
        end else begin
            ea = a_req_i && (!b_req_i || m_lcnt == LM);
            eb = b_req_i && !ea;
        end
        eaddr = ea ? a_addr_i : (eb ? b_addr_i : '0);
        edata = ea ? a_data_i : (eb ? b_data_i : 64'd0);
        ewr   = ea ? a_wr_i : (eb ? b_wr_i : 8'd0);
        if (known) begin
            chk("a_accept", a_accept_o, ea);
            chk("b_accept", b_accept_o, eb);
            chk("ram_addr", ram_addr_o, eaddr);
            chk("ram_data", ram_data_o, edata);
            chk("ram_wr", ram_wr_o, ewr);
            chk("lock_active", lock_active_o, m_lock);
            chk("a_resp_valid", a_resp_valid_o, m_arv);
            chk("a_resp_data", a_resp_data_o, m_arv ? m_ard : 64'd0);
            chk("b_resp_valid", b_resp_valid_o, m_brv);
            chk("b_resp_data", b_resp_data_o, m_brv ? m_brd : 64'd0);
        end
        trace  = {trace, a_accept_o ? "A" : (b_accept_o ? "B" : "-")};
        ltrace = {ltrace, lock_active_o ? "1" : "0"};
        bl = b_lock_i;
        if (rst_i) begin
            m_lock = 1'b0; m_starve = 0; m_lcnt = 0; m_arv = 1'b0; m_brv = 1'b0;
        end else begin
            m_arv = ea; m_brv = eb;
            if (ea) begin
                m_ard = sh_rd(a_addr_i);
                if (a_wr_i != 8'd0) begin
                    sh_mem[a_addr_i] = merge(m_ard, a_data_i, a_wr_i); sh_vld[a_addr_i] = 1'b1;
                end
            end
            if (eb) begin
                m_brd = sh_rd(b_addr_i);
                if (b_wr_i != 8'd0) begin
                    sh_mem[b_addr_i] = merge(m_brd, b_data_i, b_wr_i); sh_vld[b_addr_i] = 1'b1;
                end
            end
            m_starve = (b_req_i && !eb) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
            if (!m_lock) begin
                if (eb && bl) begin m_lock = 1'b1; m_lcnt = 0; end
            end else begin
                if (eb) m_lcnt = (m_lcnt + 1 > LM) ? LM : m_lcnt + 1;
                if (ea) m_lcnt = 0;
                if (!b_req_i || (eb && !bl)) m_lock = 1'b0;
            end
        end
        last_a_acc = ea; last_b_acc = eb;
        @(posedge clk_i);
        if (rst_i) known = 1'b1;
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        sh_mem[a] = d; sh_vld[a] = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rand_rst);
        int n = 0;
        while ((aq.size() != 0 || bq.size() != 0 || (a_req_i && !last_a_acc) ||
                (b_req_i && !last_b_acc)) && n < budget) begin
            if (rand_rst && $urandom_range(0, 299) == 0) rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
            n++;
        end
        chk("drain_bound", 64'(n < budget), 64'd1);
        tick();
        tick();
    endtask

    initial begin
        string exp_s;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("idle_a_accept", a_accept_o, 64'd0);
        chk("idle_b_accept", b_accept_o, 64'd0);
        chk("idle_ram_wr", ram_wr_o, 64'd0);
        chk("idle_ram_addr", ram_addr_o, 64'd0);
        chk("idle_lock", lock_active_o, 64'd0);
        chk("idle_a_rv", a_resp_valid_o, 64'd0);
        chk("idle_b_rv", b_resp_valid_o, 64'd0);

        // Single A read of preloaded word
        preload(13'h010, 64'h1122334455667788);
        push_a(13'h010, 64'd0, 8'h00, 0);
        trace = "";
        tick();
        chk_str("read_accept", trace, "A");
        chk("read_rv", a_resp_valid_o, 64'd1);
        chk("read_data", a_resp_data_o, 64'h1122334455667788);
        chk("read_b_rv", b_resp_valid_o, 64'd0);
        drain(50, 1'b0);

        // Both requesting continuously: 4 A grants then one forced B grant
        for (int i = 0; i < 10; i++) push_a(13'(i), 64'd0, 8'h00, 0);
        push_b(13'h011, 64'd0, 8'h00, 1'b0, 0);
        push_b(13'h012, 64'd0, 8'h00, 1'b0, 0);
        trace = "";
        for (int i = 0; i < 10; i++) tick();
        chk_str("starve_pattern", trace, "AAAABAAAAB");
        drain(100, 1'b0);

        // Locked burst of three B writes while A keeps requesting
        for (int i = 0; i < 8; i++) push_a(13'h040 + 13'(i), 64'd0, 8'h00, 0);
        push_b(13'h020, 64'hB0B0_0000_0000_0020, 8'hFF, 1'b1, 0);
        push_b(13'h021, 64'hB0B0_0000_0000_0021, 8'hFF, 1'b1, 0);
        push_b(13'h022, 64'hB0B0_0000_0000_0022, 8'hFF, 1'b0, 0);
        trace = ""; ltrace = "";
        for (int i = 0; i < 8; i++) tick();
        chk_str("lock_grants", trace, "AAAABBBA");
        chk_str("lock_active", ltrace, "00000110");
        drain(100, 1'b0);
        push_a(13'h021, 64'd0, 8'h00, 0);
        tick();
        chk("lock_readback", a_resp_data_o, 64'hB0B0_0000_0000_0021);
        drain(50, 1'b0);

        // Long lock: A squeezes in once per 16 locked B grants
        for (int i = 0; i < 60; i++) push_a(13'h100 + 13'(i), 64'd0, 8'h00, 0);
        for (int i = 0; i < 40; i++) push_b(13'h200 + 13'(i), {$urandom, $urandom}, 8'hFF, 1'b1, 0);
        trace = "";
        for (int i = 0; i < 47; i++) tick();
        exp_s = "AAAA";
        for (int i = 0; i < 17; i++) exp_s = {exp_s, "B"};
        exp_s = {exp_s, "A"};
        for (int i = 0; i < 16; i++) exp_s = {exp_s, "B"};
        exp_s = {exp_s, "A"};
        for (int i = 0; i < 7; i++) exp_s = {exp_s, "B"};
        exp_s = {exp_s, "A"};
        chk_str("lock_timeout", trace, exp_s);
        drain(200, 1'b0);

        // Partial-byte write returns pre-write word; readback shows the merge
        preload(13'h030, 64'hFFFF_FFFF_FFFF_FFFF);
        push_a(13'h030, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0);
        tick();
        chk("be_write_resp", a_resp_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        push_a(13'h030, 64'd0, 8'h00, 0);
        tick();
        chk("be_readback", a_resp_data_o, 64'hFFFF_FFFF_BBBB_BBBB);
        drain(50, 1'b0);

        // Reset right after a locked B accept
        push_b(13'h050, 64'h0505_0505_0505_0505, 8'hFF, 1'b1, 0);
        push_b(13'h051, 64'h0515_0515_0515_0515, 8'hFF, 1'b1, 0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_b_rv", b_resp_valid_o, 64'd0);
        chk("rst_lock", lock_active_o, 64'd0);
        push_a(13'h050, 64'd0, 8'h00, 0);
        trace = "";
        tick();
        chk_str("rst_first_grant", trace, "A");
        drain(50, 1'b0);

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 300; i++) begin
            push_a(13'h040 + 13'($urandom_range(0, 15)), {$urandom, $urandom},
                   ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 2));
            push_b(13'h040 + 13'($urandom_range(0, 15)), {$urandom, $urandom},
                   ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom),
                   ($urandom_range(0, 2) != 0), $urandom_range(0, 3));
        end
        drain(5000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
